// File: rtl/nar_fxp_pkg.sv
// Fixed-point types and helpers shared by the neuron accumulator, sequencer and activation stages.
package nar_fxp_pkg;

  localparam int FXP_N = 10;
  localparam int FXP_Q = 9;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN,
    WAIT_ACC,
    HOLD
  } seq_state_t;

  function automatic longint FXP_MAX(input int n);
    return (longint'(1) <<< (n - 1)) - longint'(1);
  endfunction

  function automatic longint FXP_MIN(input int n);
    return -(longint'(1) <<< (n - 1));
  endfunction

endpackage

// File: rtl/neuron_mac_sequencer_if.sv
// Sequencer-side bundle: start/busy control, operand memory port, accumulator port, result handshake.
interface neuron_mac_sequencer_if import nar_fxp_pkg::*; #(
  parameter int N     = FXP_N,
  parameter int IDX_W = 3
) ();
  logic                start;
  logic                busy;
  logic [IDX_W-1:0]    op_addr;
  logic signed [N-1:0] x_in;
  logic signed [N-1:0] w_in;
  logic signed [N-1:0] acc_a;
  logic                acc_add;
  logic                acc_rst;
  logic signed [N-1:0] acc_out;
  logic signed [N-1:0] result;
  logic                result_valid;
  logic                result_ready;

  modport master (
    input  start, x_in, w_in, acc_out, result_ready,
    output busy, op_addr, acc_a, acc_add, acc_rst, result, result_valid
  );

  modport slave (
    output start, x_in, w_in, acc_out, result_ready,
    input  busy, op_addr, acc_a, acc_add, acc_rst, result, result_valid
  );
endinterface

// File: rtl/fxp_mul_sat.sv
// Signed Q-format multiply: full product, arithmetic shift by Q (floor), saturate to N bits.
// Latency: combinational.
// Backpressure: none.
module fxp_mul_sat import nar_fxp_pkg::*; #(
  parameter int N = FXP_N,
  parameter int Q = FXP_Q
) (
  input  logic signed [N-1:0] a,
  input  logic signed [N-1:0] b,
  output logic signed [N-1:0] prod
);
  localparam logic signed [2*N-1:0] PMAX = (2*N)'(FXP_MAX(N));
  localparam logic signed [2*N-1:0] PMIN = (2*N)'(FXP_MIN(N));

  logic signed [2*N-1:0] full;
  logic signed [2*N-1:0] shifted;

  always_comb begin
    full    = $signed({{N{a[N-1]}}, a}) * $signed({{N{b[N-1]}}, b});
    shifted = full >>> Q;
    if (shifted > PMAX)      prod = PMAX[N-1:0];
    else if (shifted < PMIN) prod = PMIN[N-1:0];
    else                     prod = shifted[N-1:0];
  end
endmodule

// File: rtl/neuron_mac_sequencer.sv
// Streams FAN_IN operand pairs into the accumulator and returns the neuron sum over valid/ready.
// Latency: result_valid FAN_IN+5 cycles after start; result held until result_ready, starts ignored while busy.
module neuron_mac_sequencer import nar_fxp_pkg::*; #(
  parameter int N      = FXP_N,
  parameter int Q      = FXP_Q,
  parameter int FAN_IN = 8,
  parameter int IDX_W  = (FAN_IN > 1) ? $clog2(FAN_IN) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  neuron_mac_sequencer_if.master bus
);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(FAN_IN - 1);

  seq_state_t          state;
  logic [IDX_W-1:0]    addr_q;
  logic                v1;
  logic                v2;
  logic signed [N-1:0] acc_a_q;
  logic signed [N-1:0] result_q;
  logic                result_valid_q;
  logic signed [N-1:0] prod;

  fxp_mul_sat #(.N(N), .Q(Q)) u_mul (
    .a    (bus.x_in),
    .b    (bus.w_in),
    .prod (prod)
  );

  assign bus.busy         = (state != IDLE);
  assign bus.op_addr      = addr_q;
  assign bus.acc_a        = acc_a_q;
  assign bus.acc_add      = v2;
  // Clear stays asserted through reset so the accumulator starts empty.
  assign bus.acc_rst      = rst | (state == CLEAR);
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      addr_q         <= '0;
      v1             <= 1'b0;
      v2             <= 1'b0;
      acc_a_q        <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      v1 <= (state == RUN);
      v2 <= v1;
      if (v1) acc_a_q <= prod;

      case (state)
        IDLE:     if (bus.start) state <= CLEAR;
        CLEAR: begin
          addr_q <= '0;
          state  <= RUN;
        end
        RUN: begin
          if (addr_q == LAST) state  <= DRAIN;
          else                addr_q <= addr_q + IDX_W'(1);
        end
        // v1 low here means both pipeline stages are empty after this edge.
        DRAIN:    if (!v1) state <= WAIT_ACC;
        WAIT_ACC: begin
          result_q       <= bus.acc_out;
          result_valid_q <= 1'b1;
          state          <= HOLD;
        end
        HOLD: begin
          if (bus.result_ready) begin
            result_valid_q <= 1'b0;
            state          <= IDLE;
          end
        end
        default:  state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// Bench for neuron_mac_sequencer: FAN_IN=8 and FAN_IN=1 instances, memory/accumulator models,
// cycle-accurate checks against a fixed-point reference computed from arithmetic rules.
module tb_neuron_mac_sequencer;
  localparam int N = 10;
  localparam int Q = 9;
  localparam int SCALE = 1 << Q;
  localparam int VMAX = (1 << (N - 1)) - 1;
  localparam int VMIN = -(1 << (N - 1));

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic ready = 1'b0;
  logic sel = 1'b0;

  int nvec = 0;
  int nerr = 0;

  logic signed [N-1:0] xm8 [8];
  logic signed [N-1:0] wm8 [8];
  logic signed [N-1:0] xm1 [2];
  logic signed [N-1:0] wm1 [2];
  logic signed [N-1:0] cx [8];
  logic signed [N-1:0] cw [8];
  logic signed [N-1:0] acc8;
  logic signed [N-1:0] acc1;
  int ep [8];
  int esum;

  neuron_mac_sequencer_if #(.N(N), .IDX_W(3)) b8 ();
  neuron_mac_sequencer_if #(.N(N), .IDX_W(1)) b1 ();

  neuron_mac_sequencer #(.N(N), .Q(Q), .FAN_IN(8)) dut8 (.clk(clk), .rst(rst), .bus(b8));
  neuron_mac_sequencer #(.N(N), .Q(Q), .FAN_IN(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

  always #5 clk = ~clk;

  function automatic int clampv(input int v);
    if (v > VMAX) return VMAX;
    if (v < VMIN) return VMIN;
    return v;
  endfunction

  function automatic int sat_add(input int a, input int b);
    return clampv(a + b);
  endfunction

  // Floor of x*w / 2^Q, then clamp.
  function automatic int mul_ref(input int x, input int w);
    int p;
    int q;
    p = x * w;
    q = (p >= 0) ? p / SCALE : -((-p + SCALE - 1) / SCALE);
    return clampv(q);
  endfunction

  assign b8.start        = start & ~sel;
  assign b1.start        = start & sel;
  assign b8.result_ready = ready & ~sel;
  assign b1.result_ready = ready & sel;
  assign b8.acc_out      = acc8;
  assign b1.acc_out      = acc1;

  always @(posedge clk) begin
    b8.x_in <= xm8[b8.op_addr];
    b8.w_in <= wm8[b8.op_addr];
    b1.x_in <= xm1[b1.op_addr];
    b1.w_in <= wm1[b1.op_addr];
    if (b8.acc_rst)      acc8 <= '0;
    else if (b8.acc_add) acc8 <= N'(sat_add(int'(acc8), int'(b8.acc_a)));
    if (b1.acc_rst)      acc1 <= '0;
    else if (b1.acc_add) acc1 <= N'(sat_add(int'(acc1), int'(b1.acc_a)));
  end

  logic                m_busy, m_acc_add, m_acc_rst, m_rv;
  logic [2:0]          m_addr;
  logic signed [N-1:0] m_acc_a, m_result;
  assign m_busy    = sel ? b1.busy : b8.busy;
  assign m_acc_add = sel ? b1.acc_add : b8.acc_add;
  assign m_acc_rst = sel ? b1.acc_rst : b8.acc_rst;
  assign m_rv      = sel ? b1.result_valid : b8.result_valid;
  assign m_addr    = sel ? {2'b00, b1.op_addr} : b8.op_addr;
  assign m_acc_a   = sel ? b1.acc_a : b8.acc_a;
  assign m_result  = sel ? b1.result : b8.result;

  task automatic chk(input string tag, input int got, input int exp);
    nvec++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  task automatic fill_rand();
    for (int k = 0; k < 8; k++) begin
      cx[k] = N'($urandom_range(0, (1 << N) - 1));
      cw[k] = N'($urandom_range(0, (1 << N) - 1));
    end
  endtask

  task automatic prep(input bit s);
    int f;
    f = s ? 1 : 8;
    esum = 0;
    for (int k = 0; k < f; k++) begin
      if (s) begin
        xm1[0] = cx[k];
        wm1[0] = cw[k];
      end else begin
        xm8[k] = cx[k];
        wm8[k] = cw[k];
      end
      ep[k] = mul_ref(int'(cx[k]), int'(cw[k]));
      esum  = sat_add(esum, ep[k]);
    end
  endtask

  task automatic run_eval(input bit s, input bit early_rdy, input int hold);
    int f;
    f = s ? 1 : 8;
    @(negedge clk);
    sel = s;
    prep(s);
    ready = early_rdy;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= f + 5; c++) begin
      @(negedge clk);
      start = (c == 5);
      chk("busy", int'(m_busy), 1);
      chk("acc_rst", int'(m_acc_rst), int'(c == 1));
      chk("acc_add", int'(m_acc_add), int'(c >= 4 && c <= f + 3));
      if (c >= 4 && c <= f + 3) chk("acc_a", int'(m_acc_a), ep[c-4]);
      if (c >= 2 && c <= f + 1) chk("op_addr", int'(m_addr), c - 2);
      chk("result_valid", int'(m_rv), int'(c >= f + 5));
      if (c == f + 5) chk("result", int'(m_result), esum);
    end
    start = 1'b0;
    if (!early_rdy) begin
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        start = (h == 1);
        chk("hold_valid", int'(m_rv), 1);
        chk("hold_result", int'(m_result), esum);
        chk("hold_busy", int'(m_busy), 1);
      end
      start = 1'b0;
      ready = 1'b1;
    end
    @(negedge clk);
    ready = 1'b0;
    chk("valid_drop", int'(m_rv), 0);
    chk("idle", int'(m_busy), 0);
    @(negedge clk);
    chk("stay_idle", int'(m_busy), 0);
    chk("no_clear", int'(m_acc_rst), 0);
  endtask

  initial begin
    for (int k = 0; k < 8; k++) begin
      xm8[k] = '0;
      wm8[k] = '0;
    end
    for (int k = 0; k < 2; k++) begin
      xm1[k] = '0;
      wm1[k] = '0;
    end

    #2;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("rst_busy", int'(m_busy), 0);
      chk("rst_addr", int'(m_addr), 0);
      chk("rst_acc_a", int'(m_acc_a), 0);
      chk("rst_acc_add", int'(m_acc_add), 0);
      chk("rst_acc_rst", int'(m_acc_rst), 1);
      chk("rst_result", int'(m_result), 0);
      chk("rst_valid", int'(m_rv), 0);
    end
    sel = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 8; k++) begin
      cx[k] = 10'sd256;
      cw[k] = 10'sd256;
    end
    run_eval(1'b0, 1'b0, 5);
    for (int k = 0; k < 8; k++) cw[k] = -10'sd128;
    run_eval(1'b0, 1'b1, 0);

    cx[0] = -10'sd512;
    cw[0] = -10'sd512;
    run_eval(1'b1, 1'b0, 5);
    cw[0] = 10'sd511;
    run_eval(1'b1, 1'b1, 0);

    // Asynchronous reset while address 3 is on the bus.
    fill_rand();
    @(negedge clk);
    sel = 1'b0;
    prep(1'b0);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst_addr", int'(m_addr), 3);
    chk("pre_rst_add", int'(m_acc_add), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", int'(m_busy), 0);
    chk("arst_acc_add", int'(m_acc_add), 0);
    chk("arst_valid", int'(m_rv), 0);
    chk("arst_acc_rst", int'(m_acc_rst), 1);
    chk("arst_addr", int'(m_addr), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    fill_rand();
    run_eval(1'b0, 1'b0, 5);

    for (int i = 0; i < 20; i++) begin
      fill_rand();
      run_eval(1'b0, i[0], 3);
    end
    for (int i = 0; i < 12; i++) begin
      fill_rand();
      run_eval(1'b1, i[0], 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/neuron_mac_sequencer.md
Name: neuron_mac_sequencer

Overview:
- Upstream driver for the fixed-point neuron accumulator.
- For one neuron it streams FAN_IN input/weight pairs out of synchronous-read memories and forms saturated Q-format products.
- It pulses the accumulator's add/clear controls, captures the saturated sum, and presents it with a valid/ready handshake to the activation stage.

Parameters:
- N, 10, total signed fixed-point width (sign + integer + fraction).
- Q, 9, fractional bits.
- FAN_IN, 8, terms per neuron; must be >= 1.
- IDX_W, $clog2(FAN_IN) (minimum 1), width of the operand address.

Ports:
- clk, in, 1, system clock, rising edge.
- rst, in, 1, asynchronous active-high reset.
- start, in, 1, begin one neuron evaluation; sampled only in IDLE.
- busy, out, 1, high in every state except IDLE.
- op_addr, out, IDX_W, shared read address for the input and weight memories.
- x_in, in, N, signed input operand; valid one cycle after op_addr.
- w_in, in, N, signed weight operand; valid one cycle after op_addr.
- acc_a, out, N, saturated product to the accumulator.
- acc_add, out, 1, accumulator add strobe.
- acc_rst, out, 1, accumulator synchronous clear.
- acc_out, in, N, accumulator saturated result (combinational from its register).
- result, out, N, captured neuron sum.
- result_valid, out, 1, result available.
- result_ready, in, 1, consumer accepts result.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous, active-high.
- Reset values: state IDLE, busy 0, op_addr 0, acc_a 0, acc_add 0, result 0, result_valid 0, pipeline valid bits 0.
- acc_rst = rst OR (state==CLEAR). This holds the accumulator clear across the reset edge.
- IDLE:
  - start=1 moves to CLEAR.
  - start while not IDLE is ignored; no queuing.
- CLEAR (1 cycle): acc_rst=1, index counter := 0, then RUN.
- RUN:
  - op_addr = index, once per cycle, for index 0..FAN_IN-1.
  - v1 is set the cycle after each address (data returned).
  - Stage 2 registers the product into acc_a and sets v2.
  - acc_add = v2, so the add for index k occurs 2 cycles after its address.
  - After address FAN_IN-1, go to DRAIN.
- DRAIN: no new addresses; op_addr holds its last value. Stay until v1=0 and v2=0, then WAIT_ACC.
- WAIT_ACC (1 cycle): acc_out reflects the final add. Register result := acc_out, set result_valid, go to HOLD.
- HOLD:
  - result and result_valid stay stable until result_valid && result_ready at a clock edge.
  - On that edge: result_valid := 0, go to IDLE.
  - result_ready high on the same edge that result_valid first asserts does not complete the handshake; completion needs an edge with result_valid already 1.
- Latency: start sampled at edge 0 → acc_rst high cycle 1 → addresses cycles 2..FAN_IN+1 → acc_add high cycles 4..FAN_IN+3 → result_valid high from cycle FAN_IN+5.
- acc_add is a contiguous burst of exactly FAN_IN cycles per evaluation.
- Multiply rule:
  - Full product is 2N bits, signed, with 2Q fractional bits.
  - Arithmetic shift right by Q; truncate toward -inf.
  - Saturate to [-2^(N-1), 2^(N-1)-1].
  - Case -1.0 × -1.0 yields 2^(N-1)-1 (511 at defaults).
- Reset mid-operation: all outputs return to reset values immediately; in-flight terms are discarded. The next start begins a fresh evaluation.
- Sum saturation is the accumulator's job. This block passes acc_out through unmodified.

Decomposition:
- Shared package nar_fxp_pkg:
  - state enum {IDLE, CLEAR, RUN, DRAIN, WAIT_ACC, HOLD};
  - functions/constants FXP_MAX(N) and FXP_MIN(N);
  - default N/Q values reused by the accumulator and activation stages.
- One sub-module, fxp_mul_sat (parameters N, Q): combinational signed multiply, shift, saturate. The registered product stage stays in the sequencer.

Test Plan:
- Defaults, FAN_IN=8, all x=256 (0.5), w=256:
  - acc_rst pulse at cycle 1;
  - eight acc_add pulses at cycles 4..11, each with acc_a=128;
  - result=511 (accumulator saturates), result_valid at cycle 13.
- Mixed signs, x=256, w=-128:
  - each acc_a=-64;
  - result=-512 (0x200), exactly at the negative limit, no wrap.
- Product saturation, FAN_IN=1, x=-512, w=-512:
  - acc_a=511;
  - result=511;
  - x=-512, w=511 gives acc_a=-511.
- Handshake:
  - hold result_ready=0 for 5 cycles after result_valid: result and result_valid stable, busy=1;
  - start pulses meanwhile ignored;
  - result_ready=1 → IDLE next cycle;
  - a new start then gives a fresh clear.
- Async reset mid-RUN (assert rst between clock edges at index 3):
  - busy, acc_add, result_valid drop to 0 without waiting for a clock edge;
  - acc_rst=1 while rst is high;
  - after release, a start gives a correct full 8-term result.
